// File: rtl/multi_debouncer.sv
// N-channel push-button conditioner: 2-flop sync, steady-time qualification, press/release pulses.
// Optional auto-repeat of press pulses on held buttons when DEBOUNCE_AUTOREPEAT_EN is defined.
module multi_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int PRESSED_VALUE = 1,
  parameter int STABLE_CYCLES = 250000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] i_buttons,
  output logic [CHANNELS-1:0] o_state,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic                o_any_press
);

  localparam int              SCW         = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SCW-1:0]  STABLE_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic            IDLE_LVL    = (PRESSED_VALUE != 0) ? 1'b0 : 1'b1;
  localparam logic            PRESS_LVL   = ~IDLE_LVL;

  if (CHANNELS < 1 || STABLE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
    $error("multi_debouncer: parameter out of range");
  end

  logic [CHANNELS-1:0] press_d;
  logic                any_press_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic           s1_q, s2_q;
    logic           act;
    logic           st_q, st_d;
    logic           prs_q, prs_d;
    logic           rel_q, rel_d;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic           accept;

    assign act = (s2_q == PRESS_LVL);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int             RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             RCW         = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

    logic [RCW-1:0] rep_q, rep_d;
    // first_q selects the initial delay until the first repeat has fired
    logic           first_q, first_d;
    logic           rep_hit;

    always_comb begin
      rep_d   = rep_q;
      first_d = first_q;
      rep_hit = 1'b0;
      if (accept || !st_q) begin
        // any acceptance (press or release) or a released channel restarts the delay
        rep_d   = '0;
        first_d = 1'b1;
      end else if (rep_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
        rep_hit = 1'b1;
        rep_d   = '0;
        first_d = 1'b0;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rep_q   <= '0;
        first_q <= 1'b1;
      end else begin
        rep_q   <= rep_d;
        first_q <= first_d;
      end
    end
`else
    logic rep_hit;
    assign rep_hit = 1'b0;
`endif

    always_comb begin
      cnt_d  = cnt_q;
      st_d   = st_q;
      accept = 1'b0;
      if (act == st_q) begin
        cnt_d = '0;
      end else if (cnt_q == STABLE_LAST) begin
        accept = 1'b1;
        st_d   = act;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      prs_d = (accept && act) || rep_hit;
      rel_d = accept && !act;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q  <= IDLE_LVL;
        s2_q  <= IDLE_LVL;
        cnt_q <= '0;
        st_q  <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        s1_q  <= i_buttons[g];
        s2_q  <= s1_q;
        cnt_q <= cnt_d;
        st_q  <= st_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
      end
    end

    assign press_d[g]   = prs_d;
    assign o_state[g]   = st_q;
    assign o_press[g]   = prs_q;
    assign o_release[g] = rel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_d;
    end
  end

  assign o_any_press = any_press_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed presses/bounces/resets on an active-high and an active-low instance.
// Expected events are queued with their cycle stamp; monitors pop and compare on every DUT pulse.
module tb_multi_debouncer;

  localparam int CH  = 4;
  localparam int LAT = 10;  // drive at negedge of cycle c -> pulse visible at negedge of cycle c+10
  localparam int EW  = 29;  // {cycle[15:0], press[3:0], release[3:0], state[3:0], any}

  logic          clk;
  logic          rst;
  logic [CH-1:0] btn_a, btn_n;
  logic [CH-1:0] state_a, press_a, release_a;
  logic [CH-1:0] state_n, press_n, release_n;
  logic          any_a, any_n;
  int            cyc;
  int            tests;
  int            fails;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_n_q[$];

  multi_debouncer #(.CHANNELS(CH), .PRESSED_VALUE(1), .STABLE_CYCLES(8),
                    .REPEAT_DELAY(40), .REPEAT_PERIOD(16)) dut_a (
    .clk(clk), .rst(rst), .i_buttons(btn_a), .o_state(state_a),
    .o_press(press_a), .o_release(release_a), .o_any_press(any_a));

  multi_debouncer #(.CHANNELS(CH), .PRESSED_VALUE(0), .STABLE_CYCLES(8),
                    .REPEAT_DELAY(40), .REPEAT_PERIOD(16)) dut_n (
    .clk(clk), .rst(rst), .i_buttons(btn_n), .o_state(state_n),
    .o_press(press_n), .o_release(release_n), .o_any_press(any_n));

  // clock / reset / cycle stamp
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] ev(input int c, input logic [3:0] p, input logic [3:0] r,
                                       input logic [3:0] s, input logic a);
    return {16'(c), p, r, s, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic show_fail(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    $display("FAIL %s: got cyc=%0d p=%b r=%b s=%b any=%b, required cyc=%0d p=%b r=%b s=%b any=%b",
             name, got[28:13], got[12:9], got[8:5], got[4:1], got[0],
             exp[28:13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [EW-1:0] got, exp;
    if (press_a != 0 || release_a != 0 || any_a) begin
      got = {16'(cyc), press_a, release_a, state_a, any_a};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        show_fail("event_a_unexpected", got, '0);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          show_fail("event_a", got, exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] got, exp;
    if (press_n != 0 || release_n != 0 || any_n) begin
      got = {16'(cyc), press_n, release_n, state_n, any_n};
      tests++;
      if (exp_n_q.size() == 0) begin
        fails++;
        show_fail("event_n_unexpected", got, '0);
      end else begin
        exp = exp_n_q.pop_front();
        if (got !== exp) begin
          fails++;
          show_fail("event_n", got, exp);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // stimulus
  initial begin
    int c;
    int p;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    btn_a = '0;
    btn_n = '1;
    wait_cycles(4);
    check("reset_state_a",   32'(state_a),   32'h0);
    check("reset_press_a",   32'(press_a),   32'h0);
    check("reset_release_a", 32'(release_a), 32'h0);
    check("reset_any_a",     32'(any_a),     32'h0);
    check("reset_state_n",   32'(state_n),   32'h0);
    check("reset_any_n",     32'(any_n),     32'h0);
    rst = 1'b0;
    wait_cycles(5);

    // clean press / release on ch0
    c = cyc; btn_a[0] = 1'b1;
    exp_q.push_back(ev(c + LAT, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    wait_cycles(20);
    check("ch0_state_held", 32'(state_a), 32'h1);
    c = cyc; btn_a[0] = 1'b0;
    exp_q.push_back(ev(c + LAT, 4'b0000, 4'b0001, 4'b0000, 1'b0));
    wait_cycles(20);

    // bounce on ch1: 3-cycle pulses never qualify, then a steady press
    for (int i = 0; i < 10; i++) begin
      btn_a[1] = ~btn_a[1];
      wait_cycles(3);
    end
    check("ch1_no_accept_bounce", 32'(state_a), 32'h0);
    c = cyc; btn_a[1] = 1'b1;
    exp_q.push_back(ev(c + LAT, 4'b0010, 4'b0000, 4'b0010, 1'b1));
    wait_cycles(20);
    c = cyc; btn_a[1] = 1'b0;
    exp_q.push_back(ev(c + LAT, 4'b0000, 4'b0010, 4'b0000, 1'b0));
    wait_cycles(20);

    // simultaneous presses on ch2 and ch3
    c = cyc; btn_a[3:2] = 2'b11;
    exp_q.push_back(ev(c + LAT, 4'b1100, 4'b0000, 4'b1100, 1'b1));
    wait_cycles(20);
    check("ch23_state", 32'(state_a), 32'hC);
    c = cyc; btn_a[3:2] = 2'b00;
    exp_q.push_back(ev(c + LAT, 4'b0000, 4'b1100, 4'b0000, 1'b0));
    wait_cycles(20);

    // active-low instance on ch0
    c = cyc; btn_n[0] = 1'b0;
    exp_n_q.push_back(ev(c + LAT, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    wait_cycles(20);
    check("n_ch0_state", 32'(state_n), 32'h1);
    c = cyc; btn_n[0] = 1'b1;
    exp_n_q.push_back(ev(c + LAT, 4'b0000, 4'b0001, 4'b0000, 1'b0));
    wait_cycles(20);

    // reset while ch0 counter is at 5, button held through reset
    btn_a[0] = 1'b1;
    wait_cycles(7);
    rst = 1'b1;
    wait_cycles(1);
    check("midrst_state", 32'(state_a), 32'h0);
    check("midrst_press", 32'(press_a), 32'h0);
    c = cyc; rst = 1'b0;
    exp_q.push_back(ev(c + LAT, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    wait_cycles(20);
    c = cyc; btn_a[0] = 1'b0;
    exp_q.push_back(ev(c + LAT, 4'b0000, 4'b0001, 4'b0000, 1'b0));
    wait_cycles(20);

    // long hold on ch0: 100 cycles of accepted press
    c = cyc; p = c + LAT;
    exp_q.push_back(ev(p, 4'b0001, 4'b0000, 4'b0001, 1'b1));
`ifdef DEBOUNCE_AUTOREPEAT_EN
    exp_q.push_back(ev(p + 40, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    exp_q.push_back(ev(p + 56, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    exp_q.push_back(ev(p + 72, 4'b0001, 4'b0000, 4'b0001, 1'b1));
    exp_q.push_back(ev(p + 88, 4'b0001, 4'b0000, 4'b0001, 1'b1));
`endif
    exp_q.push_back(ev(p + 100, 4'b0000, 4'b0001, 4'b0000, 1'b0));
    btn_a[0] = 1'b1;
    wait_cycles(100);
    btn_a[0] = 1'b0;
    wait_cycles(40);

    check("final_state_a", 32'(state_a), 32'h0);
    check("pending_events_a", 32'(exp_q.size()), 32'h0);
    check("pending_events_n", 32'(exp_n_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
